// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand selection,
// operand forwarding and load-use / RAW hazard detection.
//
// Compile-time option: ID_EX_FORWARDING_EN
//   defined   : MEM/WB forwarding muxes; hazard_stall only on load-use.
//   undefined : no forwarding; hazard_stall on any RAW dependency on the
//               EX or MEM producer, held until the producer leaves MEM.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decoded instruction from ID; id_ready back to ID
//   ex_stall, ex_flush         downstream hold / branch kill
//   mem_*, wb_*                producer info from EX/MEM and MEM/WB
//   hazard_stall               stall request back to IF/ID
//   ex_*                       registered instruction and ALU operands to EX
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [3:0]            id_aluOP,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [3:0]            id_ctrl,
  input  logic                  ex_stall,
  input  logic                  ex_flush,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic [3:0]            ex_aluOP,
  output logic [XLEN-1:0]       ex_operand1,
  output logic [XLEN-1:0]       ex_operand2,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_mem_read,
  output logic                  ex_reg_write
);

  // ctrl bit positions: {use_pc, use_imm, mem_read, reg_write}
  localparam int C_USE_PC    = 3;
  localparam int C_USE_IMM   = 2;
  localparam int C_MEM_READ  = 1;
  localparam int C_REG_WRITE = 0;

  logic                  valid_q,    valid_d;
  logic [3:0]            aluop_q,    aluop_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [3:0]            ctrl_q,     ctrl_d;

  logic                  hazard_raw;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

`ifdef ID_EX_FORWARDING_EN
  logic ld_rs1_hit;
  logic ld_rs2_hit;

  // Only a load in EX needs a bubble; anything else is covered by forwarding.
  always_comb begin
    ld_rs1_hit = id_rs1_used && (id_rs1_addr == rd_addr_q);
    ld_rs2_hit = id_rs2_used && (id_rs2_addr == rd_addr_q);
    hazard_raw = id_valid && valid_q && ctrl_q[C_MEM_READ] &&
                 (rd_addr_q != '0) && (ld_rs1_hit || ld_rs2_hit);
  end

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if ((rs1_addr_q != '0) && mem_reg_write && (mem_rd_addr == rs1_addr_q)) begin
      fwd_rs1 = mem_result;
    end else if ((rs1_addr_q != '0) && wb_reg_write && (wb_rd_addr == rs1_addr_q)) begin
      fwd_rs1 = wb_result;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if ((rs2_addr_q != '0) && mem_reg_write && (mem_rd_addr == rs2_addr_q)) begin
      fwd_rs2 = mem_result;
    end else if ((rs2_addr_q != '0) && wb_reg_write && (wb_rd_addr == rs2_addr_q)) begin
      fwd_rs2 = wb_result;
    end
  end
`else
  logic ex_prod;
  logic mem_prod;
  logic rs1_dep;
  logic rs2_dep;
  logic unused_fwd;

  // Without forwarding, ID waits until the producer has left MEM; the
  // write-through regfile then supplies the value directly.
  always_comb begin
    ex_prod    = valid_q && ctrl_q[C_REG_WRITE] && (rd_addr_q != '0);
    mem_prod   = mem_reg_write && (mem_rd_addr != '0);
    rs1_dep    = id_rs1_used &&
                 ((ex_prod && (id_rs1_addr == rd_addr_q)) ||
                  (mem_prod && (id_rs1_addr == mem_rd_addr)));
    rs2_dep    = id_rs2_used &&
                 ((ex_prod && (id_rs2_addr == rd_addr_q)) ||
                  (mem_prod && (id_rs2_addr == mem_rd_addr)));
    hazard_raw = id_valid && (rs1_dep || rs2_dep);
  end

  assign fwd_rs1    = rs1_data_q;
  assign fwd_rs2    = rs2_data_q;
  assign unused_fwd = ^{mem_result, wb_result, wb_rd_addr, wb_reg_write,
                        rs1_addr_q, rs2_addr_q};
`endif

  // A flushed ID instruction is squashed upstream, so it must not stall.
  assign hazard_stall = hazard_raw && !ex_flush;
  assign id_ready     = !ex_stall && !hazard_stall;

  // Priority: flush > stall > hazard bubble > load.
  always_comb begin
    valid_d    = valid_q;
    aluop_d    = aluop_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    if (ex_flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (ex_stall) begin
      // hold everything
    end else if (hazard_stall) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d    = id_valid;
      aluop_d    = id_aluOP;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      pc_d       = id_pc;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rd_addr_d  = id_rd_addr;
      ctrl_d     = id_valid ? id_ctrl : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluop_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      aluop_q    <= aluop_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_aluOP      = aluop_q;
  assign ex_operand1   = ctrl_q[C_USE_PC]  ? pc_q  : fwd_rs1;
  assign ex_operand2   = ctrl_q[C_USE_IMM] ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_mem_read   = ctrl_q[C_MEM_READ];
  assign ex_reg_write  = ctrl_q[C_REG_WRITE] && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic            id_ready;
  logic [3:0]      id_aluOP;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [RW-1:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic            id_rs1_used, id_rs2_used;
  logic [3:0]      id_ctrl;
  logic            ex_stall, ex_flush;
  logic [RW-1:0]   mem_rd_addr, wb_rd_addr;
  logic            mem_reg_write, wb_reg_write;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            hazard_stall;
  logic            ex_valid;
  logic [3:0]      ex_aluOP;
  logic [XLEN-1:0] ex_operand1, ex_operand2, ex_store_data;
  logic [RW-1:0]   ex_rd_addr;
  logic            ex_mem_read, ex_reg_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_aluOP(id_aluOP),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_ctrl(id_ctrl),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_aluOP(ex_aluOP),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The instruction currently sitting in EX, as the pipeline rules say it should be.
  typedef struct packed {
    logic            valid;
    logic [3:0]      op;
    logic [XLEN-1:0] rs1d, rs2d, imm, pc;
    logic [RW-1:0]   rs1a, rs2a, rd;
    logic [3:0]      ctrl;   // {use_pc, use_imm, mem_read, reg_write}
  } ex_t;

  ex_t m = '0;

  function automatic logic model_hazard();
    logic h;
    logic [RW-1:0] a[2];
    logic          u[2];
    h = 1'b0;
    a[0] = id_rs1_addr; a[1] = id_rs2_addr;
    u[0] = id_rs1_used; u[1] = id_rs2_used;
    for (int s = 0; s < 2; s++) begin
`ifdef ID_EX_FORWARDING_EN
      if (m.valid && m.ctrl[1] && m.rd != 0 && u[s] && a[s] == m.rd) h = 1'b1;
`else
      if (u[s] && a[s] != 0 &&
          ((m.valid && m.ctrl[0] && m.rd == a[s]) ||
           (mem_reg_write && mem_rd_addr == a[s]))) h = 1'b1;
`endif
    end
    return h && id_valid && !ex_flush;
  endfunction

  function automatic logic [XLEN-1:0] model_src(input logic [RW-1:0] addr, input logic [XLEN-1:0] regd);
`ifdef ID_EX_FORWARDING_EN
    if (addr != 0 && mem_reg_write && mem_rd_addr == addr) return mem_result;
    if (addr != 0 && wb_reg_write && wb_rd_addr == addr) return wb_result;
`endif
    return regd;
  endfunction

  function automatic ex_t next_state();
    ex_t n;
    n = m;
    if (ex_flush) begin
      n.valid = 1'b0; n.ctrl = 4'b0;
    end else if (!ex_stall) begin
      if (model_hazard()) begin
        n.valid = 1'b0; n.ctrl = 4'b0;
      end else begin
        n.valid = id_valid; n.op = id_aluOP;
        n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.imm = id_imm; n.pc = id_pc;
        n.rs1a = id_rs1_addr; n.rs2a = id_rs2_addr; n.rd = id_rd_addr;
        n.ctrl = id_valid ? id_ctrl : 4'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= next_state();
  end

  // Compare every cycle, on the falling edge, when inputs are stable.
  always @(negedge clk) begin
    logic [XLEN-1:0] s1, s2;
    logic            hz;
    s1 = model_src(m.rs1a, m.rs1d);
    s2 = model_src(m.rs2a, m.rs2d);
    hz = model_hazard();
    chk("cmp_ex_valid",   32'(ex_valid),     32'(m.valid));
    chk("cmp_aluop",      32'(ex_aluOP),     32'(m.op));
    chk("cmp_operand1",   ex_operand1,       m.ctrl[3] ? m.pc : s1);
    chk("cmp_operand2",   ex_operand2,       m.ctrl[2] ? m.imm : s2);
    chk("cmp_store_data", ex_store_data,     s2);
    chk("cmp_rd_addr",    32'(ex_rd_addr),   32'(m.rd));
    chk("cmp_mem_read",   32'(ex_mem_read),  32'(m.ctrl[1]));
    chk("cmp_reg_write",  32'(ex_reg_write), 32'(m.ctrl[0] && m.valid));
    chk("cmp_hazard",     32'(hazard_stall), 32'(hz));
    chk("cmp_id_ready",   32'(id_ready),     32'(!ex_stall && !hz));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_instr(input logic [3:0] op, input logic [31:0] r1d, input logic [31:0] r2d,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [3:0] ctrl);
    id_valid = 1'b1; id_aluOP = op; id_rs1_data = r1d; id_rs2_data = r2d;
    id_imm = imm; id_pc = pc; id_rs1_addr = r1a; id_rs2_addr = r2a; id_rd_addr = rd;
    id_rs1_used = u1; id_rs2_used = u2; id_ctrl = ctrl;
  endtask

  task automatic id_idle();
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_ctrl = 4'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_aluOP = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_ctrl = 0; ex_stall = 0; ex_flush = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    #3;
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_hazard", 32'(hazard_stall), 32'd0);
    @(posedge clk); #11;
    rst_n = 1'b1;

    // use_pc / use_imm operand selection
    id_instr(4'b0000, 32'h11, 32'h22, 32'h4, 32'h100, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 4'b1101);
    tick();
    id_idle();
    chk("pcimm_operand1", ex_operand1, 32'h100);
    chk("pcimm_operand2", ex_operand2, 32'h4);
    chk("pcimm_reg_write", 32'(ex_reg_write), 32'd1);

    // forwarding priority on rs1
    id_instr(4'b0001, 32'h5555, 32'h6666, 32'h0, 32'h0, 5'd5, 5'd6, 5'd10, 1'b1, 1'b1, 4'b0001);
    tick();
    id_idle();
    mem_rd_addr = 5'd5; mem_result = 32'hAAAA; mem_reg_write = 1'b1;
    wb_rd_addr = 5'd5; wb_result = 32'hBBBB; wb_reg_write = 1'b1;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("fwd_mem_over_wb", ex_operand1, 32'hAAAA);
`else
    chk("nofwd_rs1_reg", ex_operand1, 32'h5555);
`endif
    mem_reg_write = 1'b0;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("fwd_wb", ex_operand1, 32'hBBBB);
`else
    chk("nofwd_rs1_reg2", ex_operand1, 32'h5555);
`endif
    wb_reg_write = 1'b0;
    id_instr(4'b0000, 32'h7777, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 4'b0001);
    tick();
    id_idle();
    mem_rd_addr = 5'd0; mem_result = 32'hAAAA; mem_reg_write = 1'b1;
    #1;
    chk("x0_not_forwarded", ex_operand1, 32'h7777);
    mem_reg_write = 1'b0;
    tick();

`ifdef ID_EX_FORWARDING_EN
    // load-use: one bubble, then forward from MEM
    id_instr(4'b0000, 32'h1000, 32'h2000, 32'h0, 32'h0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 4'b0011);
    tick();
    id_instr(4'b0000, 32'h1, 32'h9999, 32'h0, 32'h0, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 4'b0001);
    #1;
    chk("lu_hazard", 32'(hazard_stall), 32'd1);
    chk("lu_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
    id_idle();
    mem_rd_addr = 5'd7; mem_result = 32'h1234; mem_reg_write = 1'b1;
    #1;
    chk("lu_captured", 32'(ex_rd_addr), 32'd8);
    chk("lu_operand2", ex_operand2, 32'h1234);
    tick();
    mem_reg_write = 1'b0;
`else
    // RAW without forwarding: stall while producer is in EX and in MEM
    id_instr(4'b0000, 32'h30, 32'h31, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 4'b0001);
    tick();
    id_instr(4'b0000, 32'h77, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 4'b0001);
    #1;
    chk("raw_stall_ex", 32'(hazard_stall), 32'd1);
    tick();
    mem_rd_addr = 5'd3; mem_reg_write = 1'b1;
    #1;
    chk("raw_bubble", 32'(ex_valid), 32'd0);
    chk("raw_stall_mem", 32'(hazard_stall), 32'd1);
    tick();
    mem_reg_write = 1'b0; wb_rd_addr = 5'd3; wb_reg_write = 1'b1;
    #1;
    chk("raw_stall_release", 32'(hazard_stall), 32'd0);
    chk("raw_still_bubble", 32'(ex_valid), 32'd0);
    tick();
    id_idle();
    wb_reg_write = 1'b0;
    chk("raw_captured_rd", 32'(ex_rd_addr), 32'd4);
    chk("raw_captured_op1", ex_operand1, 32'h77);
    tick();
`endif

    // flush beats stall; stall holds everything
    id_instr(4'b0101, 32'hA1, 32'hA2, 32'h0, 32'h0, 5'd12, 5'd13, 5'd14, 1'b0, 1'b0, 4'b0001);
    tick();
    id_instr(4'b0110, 32'hB1, 32'hB2, 32'h0, 32'h0, 5'd15, 5'd16, 5'd17, 1'b1, 1'b1, 4'b0001);
    ex_flush = 1'b1; ex_stall = 1'b1;
    tick();
    ex_flush = 1'b0; ex_stall = 1'b0;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
    tick();
    id_instr(4'b0111, 32'hC1, 32'hC2, 32'h0, 32'h0, 5'd20, 5'd21, 5'd18, 1'b0, 1'b0, 4'b0001);
    ex_stall = 1'b1;
    #1;
    chk("stall_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("stall_hold_op", 32'(ex_aluOP), 32'h6);
    chk("stall_hold_rd", 32'(ex_rd_addr), 32'd17);
    chk("stall_hold_op1", ex_operand1, 32'hB1);
    chk("stall_hold_valid", 32'(ex_valid), 32'd1);
    ex_stall = 1'b0;
    id_idle();
    tick();

    // async reset mid-operation
    id_instr(4'b0001, 32'h1, 32'h2, 32'h0, 32'h0, 5'd22, 5'd23, 5'd19, 1'b0, 1'b0, 4'b0001);
    tick();
    id_idle();
    chk("pre_reset_valid", 32'(ex_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_aluop", 32'(ex_aluOP), 32'd0);
    chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    tick();
    rst_n = 1'b1;

    // mixed vectors over a small register range to provoke collisions
    for (int i = 0; i < 200; i++) begin
      tick();
      id_valid      = ($urandom_range(0, 3) != 0);
      id_aluOP      = 4'($urandom_range(0, 9));
      id_rs1_data   = $urandom; id_rs2_data = $urandom;
      id_imm        = $urandom; id_pc = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 3));
      id_rs2_addr   = 5'($urandom_range(0, 3));
      id_rd_addr    = 5'($urandom_range(0, 3));
      id_rs1_used   = 1'($urandom_range(0, 1));
      id_rs2_used   = 1'($urandom_range(0, 1));
      id_ctrl       = 4'($urandom_range(0, 15));
      ex_flush      = ($urandom_range(0, 7) == 0);
      ex_stall      = ($urandom_range(0, 3) == 0);
      mem_rd_addr   = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_result    = $urandom;
      wb_rd_addr    = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_result     = $urandom;
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
